// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial adder sequencer.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Smallest operand width the sequencer supports.
   localparam int MIN_W = 2;

   // Bit counter width: enough to hold W-1, never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= MIN_W) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_add_bit_cell.sv
// One-bit full adder used by the serial sequencer; purely combinational.
module serial_add_bit_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic ab_x;

   // Sum and carry from XOR/AND/OR only.
   always_comb begin
      ab_x = a ^ b;
      s    = ab_x ^ cin;
      cout = (a & b) | (cin & ab_x);
   end

endmodule

// File: rtl/serial_add_sequencer.sv
// W-bit adder built from a single full-adder cell, operands shifted LSB-first.
// Optional subtract mode is enabled with the SERIAL_ADD_SUB_EN macro, which
// also adds the in_sub port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | one result bit per cycle, W cycles
// DONE  | result held on out_sum/out_carry, out_valid high until taken
module serial_add_sequencer
   import serial_add_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
`ifdef SERIAL_ADD_SUB_EN
   input  logic         in_sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_carry
);

   localparam int            CW       = cnt_width(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   state_t        state;
   state_t        state_nxt;
   logic [W-1:0]  a_sr;
   logic [W-1:0]  b_sr;
   logic [W-1:0]  sum_sr;
   logic          carry;
   logic [CW-1:0] cnt;
   logic          sum_bit;
   logic          carry_d;
   logic          accept;
   logic          last_bit;
   logic          sub_req;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_req = in_sub;
`else
   assign sub_req = 1'b0;
`endif

   assign accept   = in_valid & in_ready;
   assign last_bit = (state == RUN) && (cnt == CNT_LAST);
   assign out_sum  = sum_sr;

   serial_add_bit_cell u_bit_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (sum_bit),
      .cout (carry_d)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs follow the state directly.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Shift registers, carry, counter and carry-out capture.
   // Subtraction is a + ~b + 1, so b is inverted and carry starts at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         out_carry <= 1'b0;
      end else if (accept) begin
         a_sr  <= in_a;
         b_sr  <= sub_req ? ~in_b : in_b;
         carry <= sub_req;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_sr <= {sum_bit, sum_sr[W-1:1]};
         carry  <= carry_d;
         if (last_bit) out_carry <= carry_d;
         else          cnt       <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at W=8.
module tb_serial_add_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_a = '0;
   logic [7:0] in_b = '0;
   logic       in_sub = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_sum;
   logic       out_carry;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_add_sequencer #(.W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef SERIAL_ADD_SUB_EN
      .in_sub    (in_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for in_ready at a negedge, then presents one operation.
   task automatic accept_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic sub);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 8'hA5;
      in_b     = 8'h5A;
   endtask

   // Full op: latency, result, optional held DONE cycles, single handshake.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] es, input logic ec,
                         input int hold);
      int lat;
      out_ready = 1'b0;
      accept_op(tag, a, b, sub);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd8);
      check({tag, "_sum"}, 32'(out_sum), 32'(es));
      check({tag, "_carry"}, 32'(out_carry), 32'(ec));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_sum"}, 32'(out_sum), 32'(es));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int         low_cnt;
      int         n;
      logic [7:0] first_sum;
      logic       first_carry;
      logic       seen_valid;

      // Reset values.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_carry", 32'(out_carry), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic additions, first one held in DONE for 5 cycles.
      run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 5);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
      run_op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);

      // One handshake only: out_valid stays low and out_sum is not cleared.
      run_op("hold_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5);
      seen_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (out_valid) seen_valid = 1'b1;
      end
      check("one_handshake", 32'(seen_valid), 32'd0);
      check("sum_kept_after_hs", 32'(out_sum), 32'h46);

      // Back-to-back with out_ready high; in_valid stays up across RUN.
      @(negedge clk);
      out_ready = 1'b1;
      in_a      = 8'hFF;
      in_b      = 8'hFF;
      in_sub    = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_a        = 8'h01;
      in_b        = 8'h00;
      low_cnt     = 0;
      first_sum   = 8'h00;
      first_carry = 1'b0;
      while (!in_ready && low_cnt < 30) begin
         low_cnt++;
         if (out_valid) begin
            first_sum   = out_sum;
            first_carry = out_carry;
         end
         @(posedge clk);
         #1;
      end
      check("b2b_ready_low", 32'(low_cnt), 32'd9);
      check("b2b_first_sum", 32'(first_sum), 32'hFE);
      check("b2b_first_carry", 32'(first_carry), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b_second_lat", 32'(n), 32'd8);
      check("b2b_second_sum", 32'(out_sum), 32'h01);
      check("b2b_second_carry", 32'(out_carry), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("b2b_done", 32'(in_ready), 32'd1);

      // Reset during RUN cycle 4 aborts the operation.
      accept_op("abort", 8'h77, 8'h11, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_out_sum", 32'(out_sum), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_valid = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) seen_valid = 1'b1;
      end
      check("abort_no_valid", 32'(seen_valid), 32'd0);
      run_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
      run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 0);
      run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 0);
      run_op("add_after_sub", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
